// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the clock_divider_bank block.
//   clkdiv_state_e   : per-channel FSM state
//   CLKDIV_MIN_RATIO : smallest legal divide ratio
//   clkdiv_norm()    : maps ratios 0 and 1 to CLKDIV_MIN_RATIO
package clkdiv_pkg;

  typedef enum logic [1:0] {
    CLKDIV_IDLE  = 2'd0,
    CLKDIV_RUN   = 2'd1,
    CLKDIV_DRAIN = 2'd2
  } clkdiv_state_e;

  localparam int unsigned CLKDIV_MIN_RATIO = 2;

  // Ratios below the minimum cannot produce a high and a low phase.
  function automatic logic [31:0] clkdiv_norm(input logic [31:0] d);
    return (d < 32'(CLKDIV_MIN_RATIO)) ? 32'(CLKDIV_MIN_RATIO) : d;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divided-clock channel (FSM, period counter, shadow ratio,
// optional rising-edge counter).
// Optional feature macro: CLKDIV_EDGE_CNT_EN (edge counter).
// Ports:
//   clk_ref, rst    : reference clock, async active-high reset
//   gate_en_i       : run request (level)
//   align_i         : phase restart pulse
//   cfg_we_i        : config transfer for this channel this cycle
//   cfg_div_i       : normalised new ratio
//   edge_clr_i      : clear edge counter
//   clk_out_o       : divided clock (flop output)
//   busy_o          : channel not idle
//   pend_o          : shadow ratio waiting for a period boundary
//   edge_cnt_o      : saturating count of clk_out_o rising edges
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             gate_en_i,
  input  logic             align_i,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             edge_clr_i,
  output logic             clk_out_o,
  output logic             busy_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  clkdiv_state_e    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             wrap;
  logic             apply_pend;

  // Next-state, counter and ratio update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    apply_pend = 1'b0;
    wrap       = (cnt_q == (ratio_q - DIV_W'(1)));

    case (state_q)
      CLKDIV_IDLE: begin
        cnt_d      = '0;
        apply_pend = pend_q;
        if (gate_en_i) state_d = CLKDIV_RUN;
      end
      CLKDIV_RUN, CLKDIV_DRAIN: begin
        if (align_i) begin
          // Restart the period; a draining channel still stops at its next wrap.
          cnt_d      = '0;
          apply_pend = pend_q;
          state_d    = gate_en_i ? CLKDIV_RUN : CLKDIV_DRAIN;
        end else if (wrap) begin
          cnt_d      = '0;
          apply_pend = pend_q;
          state_d    = gate_en_i ? CLKDIV_RUN : CLKDIV_IDLE;
        end else begin
          cnt_d   = cnt_q + DIV_W'(1);
          state_d = gate_en_i ? CLKDIV_RUN : CLKDIV_DRAIN;
        end
      end
      default: begin
        state_d = CLKDIV_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (apply_pend) begin
      ratio_d = shadow_q;
      pend_d  = 1'b0;
    end

    // A transfer only happens while pend is clear, so it never races apply_pend.
    if (cfg_we_i) begin
      shadow_d = cfg_div_i;
      if (state_q == CLKDIV_IDLE) ratio_d = cfg_div_i;
      else                        pend_d  = 1'b1;
    end

    out_d  = (state_d != CLKDIV_IDLE) && (cnt_d < (ratio_d >> 1));
    busy_d = (state_d != CLKDIV_IDLE);
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q  <= CLKDIV_IDLE;
      cnt_q    <= '0;
      ratio_q  <= DIV_W'(DIV_RST);
      shadow_q <= DIV_W'(DIV_RST);
      pend_q   <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
    end
  end

  assign clk_out_o = out_q;
  assign busy_o    = busy_q;
  assign pend_o    = pend_q;

`ifdef CLKDIV_EDGE_CNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Count rising edges as the output flop is loaded; clear has priority.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (edge_clr_i)
      edge_cnt_d = '0;
    else if (out_d && !out_q && (edge_cnt_q != '1))
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) edge_cnt_q <= '0;
    else     edge_cnt_q <= edge_cnt_d;
  end

  assign edge_cnt_o = edge_cnt_q;
`else
  logic unused_edge_clr;
  assign unused_edge_clr = edge_clr_i;
  assign edge_cnt_o      = '0;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: OUTPUTS independently gated, runtime-programmable integer
// dividers of clk_ref with glitch-free gating and a global phase align.
// Optional feature macro: CLKDIV_EDGE_CNT_EN (per-channel rising-edge counters).
// Ports:
//   clk_ref, rst            : reference clock, async active-high reset
//   gate_en_i[OUTPUTS]      : per-channel run request
//   align_i                 : phase-restart pulse for all running channels
//   cfg_valid_i/cfg_ready_o : ratio config handshake
//   cfg_ch_i, cfg_div_i     : target channel and new ratio
//   edge_clr_i              : clear all edge counters
//   clk_out_o[OUTPUTS]      : divided clocks
//   busy_o[OUTPUTS]         : channel not idle
//   edge_cnt_o              : OUTPUTS x CNT_W edge counts (channel 0 in LSBs)
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned OUTPUTS = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned CH_W   = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) (
  input  logic                     clk_ref,
  input  logic                     rst,
  input  logic [OUTPUTS-1:0]       gate_en_i,
  input  logic                     align_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [DIV_W-1:0]         cfg_div_i,
  input  logic                     edge_clr_i,
  output logic [OUTPUTS-1:0]       clk_out_o,
  output logic [OUTPUTS-1:0]       busy_o,
  output logic [OUTPUTS*CNT_W-1:0] edge_cnt_o
);

  logic [OUTPUTS-1:0] pend;
  logic [OUTPUTS-1:0] cfg_we_c;
  logic [DIV_W-1:0]   cfg_div_norm;
  logic               ready_c;

  assign cfg_div_norm = DIV_W'(clkdiv_norm(32'(cfg_div_i)));

  // Ready mux; channel numbers beyond OUTPUTS stay ready and are dropped.
  always_comb begin
    ready_c = 1'b1;
    for (int unsigned c = 0; c < OUTPUTS; c++) begin
      if (cfg_ch_i == CH_W'(c)) ready_c = !pend[c];
    end
  end

  // Config decode.
  always_comb begin
    cfg_we_c = '0;
    for (int unsigned c = 0; c < OUTPUTS; c++) begin
      cfg_we_c[c] = cfg_valid_i && ready_c && (cfg_ch_i == CH_W'(c));
    end
  end

  assign cfg_ready_o = ready_c;

  for (genvar c = 0; c < int'(OUTPUTS); c++) begin : g_ch
    clkdiv_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk_ref    (clk_ref),
      .rst        (rst),
      .gate_en_i  (gate_en_i[c]),
      .align_i    (align_i),
      .cfg_we_i   (cfg_we_c[c]),
      .cfg_div_i  (cfg_div_norm),
      .edge_clr_i (edge_clr_i),
      .clk_out_o  (clk_out_o[c]),
      .busy_o     (busy_o[c]),
      .pend_o     (pend[c]),
      .edge_cnt_o (edge_cnt_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: table-driven check of clock_divider_bank with a
// scoreboard queue of expected per-cycle outputs.
module tb_clock_divider_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  gate_en = '0;
  logic        align = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [7:0]  cfg_div = '0;
  logic        edge_clr = 1'b0;
  logic [3:0]  clk_out;
  logic [3:0]  busy;
  logic [63:0] edge_cnt;

  clock_divider_bank #(
    .OUTPUTS (4),
    .DIV_W   (8),
    .DIV_RST (2),
    .CNT_W   (16)
  ) dut (
    .clk_ref     (clk),
    .rst         (rst),
    .gate_en_i   (gate_en),
    .align_i     (align),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .edge_clr_i  (edge_clr),
    .clk_out_o   (clk_out),
    .busy_o      (busy),
    .edge_cnt_o  (edge_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gate;
    logic       al;
    logic       cv;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [3:0] eo;
    logic [3:0] eb;
    logic       er;
  } vec_t;

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] busy;
    logic       rdy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] g, input logic al, input logic cv,
                              input logic [1:0] ch, input logic [7:0] dv,
                              input logic [3:0] eo, input logic [3:0] eb, input logic er);
    vec_t v;
    v.gate = g; v.al = al; v.cv = cv; v.ch = ch; v.dv = dv;
    v.eo = eo; v.eb = eb; v.er = er;
    vecs.push_back(v);
  endfunction

  // Plain cycle: no align, no config.
  function automatic void addp(input logic [3:0] g, input logic [1:0] ch,
                               input logic [3:0] eo, input logic [3:0] eb, input logic er);
    add(g, 1'b0, 1'b0, ch, 8'd0, eo, eb, er);
  endfunction

  // Drive each vector after a falling edge, compare after the next rising edge.
  task automatic run_vecs(input string tag);
    exp_t x;
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      gate_en   = vecs[i].gate;
      align     = vecs[i].al;
      cfg_valid = vecs[i].cv;
      cfg_ch    = vecs[i].ch;
      cfg_div   = vecs[i].dv;
      x.out = vecs[i].eo; x.busy = vecs[i].eb; x.rdy = vecs[i].er;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s[%0d].out", tag, i),  64'(clk_out),   64'(e.out));
      check($sformatf("%s[%0d].busy", tag, i), 64'(busy),      64'(e.busy));
      check($sformatf("%s[%0d].rdy", tag, i),  64'(cfg_ready), 64'(e.rdy));
    end
    vecs.delete();
    align     = 1'b0;
    cfg_valid = 1'b0;
    edge_clr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    gate_en = '0; align = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; edge_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p5 [10];
    int   n;
    p5 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values.
    do_reset();
    check("rst.out",  64'(clk_out),   64'h0);
    check("rst.busy", 64'(busy),      64'h0);
    check("rst.rdy",  64'(cfg_ready), 64'h1);
    check("rst.edge", edge_cnt,       64'h0);

    // Default D=2 on channel 0.
    for (int i = 0; i < 6; i++)
      addp(4'b0001, 2'd0, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001, 1'b1);
    run_vecs("d2");

    // Channel 1 configured to D=5 while idle, then enabled.
    do_reset();
    add(4'b0000, 1'b0, 1'b1, 2'd1, 8'd5, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++)
      addp(4'b0010, 2'd1, p5[i] ? 4'b0010 : 4'b0000, 4'b0010, 1'b1);
    run_vecs("d5");

    // Channel 0 D=4 -> D=6 while running; ready low until the wrap.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd0, 8'd4, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    add (4'b0001, 1'b0, 1'b1, 2'd0, 8'd6, 4'b0000, 4'b0001, 1'b0);
    addp(4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b0);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    run_vecs("retune");

    // Channel 2 D=8, gate dropped at cnt=1: high phase completes, stops at wrap.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd2, 8'd8, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0000, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0000, 2'd2, 4'b0100, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) addp(4'b0000, 2'd2, 4'b0000, 4'b0100, 1'b1);
    addp(4'b0000, 2'd2, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0000, 2'd2, 4'b0000, 4'b0000, 1'b1);
    run_vecs("drain");

    // Same, but gate re-asserted during DRAIN: period continues unbroken.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd2, 8'd8, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0000, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) addp(4'b0100, 2'd2, 4'b0000, 4'b0100, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    addp(4'b0100, 2'd2, 4'b0100, 4'b0100, 1'b1);
    run_vecs("reassert");

    // D=3/4/6 at staggered phases, then align.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd0, 8'd3, 4'b0000, 4'b0000, 1'b1);
    add (4'b0000, 1'b0, 1'b1, 2'd1, 8'd4, 4'b0000, 4'b0000, 1'b1);
    add (4'b0000, 1'b0, 1'b1, 2'd2, 8'd6, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0011, 2'd0, 4'b0010, 4'b0011, 1'b1);
    addp(4'b0111, 2'd0, 4'b0110, 4'b0111, 1'b1);
    addp(4'b0111, 2'd0, 4'b0101, 4'b0111, 1'b1);
    add (4'b0111, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0111, 4'b0111, 1'b1);
    addp(4'b0111, 2'd0, 4'b0110, 4'b0111, 1'b1);
    addp(4'b0111, 2'd0, 4'b0100, 4'b0111, 1'b1);
    addp(4'b0111, 2'd0, 4'b0001, 4'b0111, 1'b1);
    run_vecs("align");

    // Align applies a pending ratio immediately.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd0, 8'd4, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    add (4'b0001, 1'b0, 1'b1, 2'd0, 8'd1, 4'b0001, 4'b0001, 1'b0);
    add (4'b0001, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0000, 4'b0001, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    run_vecs("align_pend");

    // Bounded wait for busy to fall after a disable (ch1 D=6, dropped at cnt=1).
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd1, 8'd6, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0010, 2'd1, 4'b0010, 4'b0010, 1'b1);
    addp(4'b0010, 2'd1, 4'b0010, 4'b0010, 1'b1);
    run_vecs("dis_pre");
    gate_en = 4'b0000;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy[1] == 1'b0) break;
    end
    check("dis.busy_fall_cycles", 64'(n), 64'd5);
    check("dis.out_low", 64'(clk_out), 64'h0);

    // Reset mid-period: outputs drop without a clock edge, pending config lost.
    do_reset();
    add (4'b0000, 1'b0, 1'b1, 2'd0, 8'd4, 4'b0000, 4'b0000, 1'b1);
    addp(4'b0001, 2'd0, 4'b0001, 4'b0001, 1'b1);
    add (4'b0001, 1'b0, 1'b1, 2'd0, 8'd6, 4'b0001, 4'b0001, 1'b0);
    run_vecs("mid_pre");
    gate_en = 4'b0001;
    #2 rst = 1'b1;
    #1;
    check("mid_rst.out",  64'(clk_out),   64'h0);
    check("mid_rst.busy", 64'(busy),      64'h0);
    check("mid_rst.rdy",  64'(cfg_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;

`ifdef CLKDIV_EDGE_CNT_EN
    // Edge counter: 10 periods of D=2 on ch3, clear on a rising edge, saturation.
    do_reset();
    gate_en = 4'b1000;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("edge.count10", 64'(edge_cnt[63:48]), 64'd10);
    edge_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    edge_clr = 1'b0;
    check("edge.clr_out_rising", 64'(clk_out[3]), 64'h1);
    check("edge.clr_wins", 64'(edge_cnt[63:48]), 64'd0);
    force dut.g_ch[3].u_ch.edge_cnt_q = 16'hFFFE;
    #1;
    release dut.g_ch[3].u_ch.edge_cnt_q;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("edge.saturate", 64'(edge_cnt[63:48]), 64'hFFFF);
`else
    // Without the counters the bus stays zero whatever the channels do.
    do_reset();
    gate_en  = 4'b1111;
    edge_clr = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    edge_clr = 1'b0;
    check("edge.tied_busy", 64'(busy), 64'hF);
    check("edge.tied_zero", edge_cnt, 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised successor to the fixed-ratio clock distributor: `OUTPUTS` independent channels, each with a runtime-programmable integer divider of `clk_ref`. Gating is glitch-free and only takes effect at period boundaries. Ratio changes go through a valid/ready config port and apply at the next period boundary. A global align pulse phase-restarts all running channels. It sits between the RCD reference clock and the per-rank/per-channel output clock buffers.

## Interface
- `OUTPUTS`, 4: number of output channels (1..16).
- `DIV_W`, 8: divider ratio field width; legal ratio D is 2..2^DIV_W-1.
- `DIV_RST`, 2: ratio loaded into every channel at reset.
- `CNT_W`, 16: edge-counter width (used only with `CLKDIV_EDGE_CNT_EN`).
- `clk_ref` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: reset. It is asynchronous and active-high (asserts asynchronously; deassertion is synchronised upstream).
- `gate_en_i` in OUTPUTS: per-channel run request, level-sensitive.
- `align_i` in 1: single-cycle phase-restart pulse.
- `cfg_valid_i` in 1: config request valid.
- `cfg_ready_o` out 1: config accept.
- `cfg_ch_i` in max(1,$clog2(OUTPUTS)): target channel.
- `cfg_div_i` in DIV_W: new ratio D.
- `edge_clr_i` in 1: clears all edge counters.
- `clk_out_o` out OUTPUTS: divided clocks, each driven directly from a flop.
- `busy_o` out OUTPUTS: channel not in IDLE.
- `edge_cnt_o` out OUTPUTS×CNT_W: rising-edge count per channel.

## Operation
- Per-channel state: `ratio` (DIV_W), `pend` flag with `shadow` ratio, counter `cnt` (0..ratio-1), FSM {IDLE, RUN, DRAIN}.
- Ratio normalisation: D=0 or D=1 is stored as 2.
- High time is floor(D/2) cycles and low time is D-floor(D/2) cycles. Odd D gives a longer low phase.
- `clk_out_o[c]` is a flop loaded with (next_state != IDLE) && (cnt_next < floor(ratio_next/2)).
- IDLE:
  - cnt=0, out=0.
  - Sampled `gate_en_i[c]`=1 → RUN, cnt=0, pending ratio applied.
- RUN:
  - cnt increments and wraps at ratio-1.
  - At wrap, if `pend`, then ratio←shadow and pend←0.
  - Sampled `gate_en_i[c]`=0 → DRAIN.
- DRAIN:
  - Counts as RUN, to finish the current period.
  - At wrap → IDLE with out=0, so no truncated high pulse.
  - `gate_en_i[c]`=1 during DRAIN → back to RUN with no phase disturbance.
- Config port:
  - `cfg_ready_o` = !pend[cfg_ch_i].
  - A transfer occurs when valid&&ready: shadow←normalised cfg_div_i, pend←1.
  - If the target channel is IDLE, ratio is applied the next cycle and pend clears.
  - `cfg_ch_i` ≥ OUTPUTS: accepted (ready=1) and discarded.
- Align:
  - Sampled `align_i`=1 sets cnt=0 on every RUN/DRAIN channel and applies any pend already set.
  - out=1 the next cycle, provided the ratio after apply is ≥2 (always true).
  - IDLE channels are unaffected.
- Simultaneous align and config transfer on the same channel: align applies the old pend state; the new shadow applies at the next wrap.
- Align during DRAIN restarts the period; the channel still stops at the next wrap.
- `busy_o[c]` = state != IDLE.

## Timing
- Reset values:
  - `clk_out_o`=0, `busy_o`=0, `cfg_ready_o`=1, `edge_cnt_o`=0.
  - All FSMs IDLE, ratio=DIV_RST, pend=0.
- Enable latency: gate_en sampled high at edge k → out=1 from edge k+1 for floor(D/2) cycles.
- Disable: out reaches 0 at the end of the current high phase and stays 0. `busy_o` falls at the wrap edge.
- Ratio change in RUN takes effect at the first wrap after the transfer. `cfg_ready_o` for that channel is low until then.
- Align latency: 1 cycle. All aligned channels rise on the same edge.
- Reset mid-period: outputs drop asynchronously to 0. Pending config is lost.

## Configuration
- `CLKDIV_EDGE_CNT_EN`:
  - Defined: per-channel CNT_W rising-edge counters. They increment on each 0→1 of `clk_out_o[c]` and saturate at all-ones. `edge_clr_i` zeroes all counters; a clear wins over a same-cycle increment.
  - Undefined: `edge_cnt_o` is tied to 0, `edge_clr_i` is ignored, and no counter flops are built.

## Structure
- Package `clkdiv_pkg`:
  - FSM state enum `clkdiv_state_e`.
  - Constant `CLKDIV_MIN_RATIO`=2.
  - Normalisation function `clkdiv_norm`.
- Sub-module `clkdiv_channel`: one channel's FSM, counter, shadow and (optional) edge counter. The top does config decode, align fan-out and the ready mux.

## Test plan
- Reset, gate_en=4'b0001, default D=2 → out[0] toggles 1,0,1,0 starting one cycle after enable; other outputs stay 0.
- Config ch1 D=5 while IDLE, then enable → out[1] high 2 cycles, low 3, repeating; `cfg_ready_o` stays 1 throughout.
- Ch0 running D=4; config D=6 at cnt=1 → `cfg_ready_o` low until the wrap, then the pattern becomes 3 high / 3 low with no short pulse.
- Ch2 running D=8; drop gate_en at cnt=1 → the high phase completes (4 cycles), out stays 0, `busy_o[2]` falls at the wrap. Re-assert during DRAIN instead → the period continues unbroken.
- Channels with D=3/4/6 running at arbitrary phases; pulse align_i → all outputs rise on the same edge one cycle later.
- Macro defined: run ch3 D=2 for 10 periods → `edge_cnt_o[3]`=10. Pulse edge_clr_i concurrent with a rising edge → 0. Preload the counter near max → it holds 16'hFFFF.
